// File: rtl/arith_engine.sv
// arith_engine: unsigned add/sub (1 cycle), shift-add mul and restoring div (WIDTH cycles) with valid/ready.
// Divider is built only when ARITH_ENGINE_DIV_EN is defined; otherwise op 11 returns error.
module arith_engine #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             error
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [2*WIDTH-1:0] p, p_next;
  logic [WIDTH:0] sum, mac;
  logic is_div;
  assign sum = op[0] ? {1'b0, operand_a} - {1'b0, operand_b} : {1'b0, operand_a} + {1'b0, operand_b};
  // p holds {partial product high, remaining multiplier bits}; one bit retired per cycle
  assign mac = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_r} : '0);
`ifdef ARITH_ENGINE_DIV_EN
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0] trial;
  logic ge;
  // for division p holds {partial remainder, dividend/quotient}; remainder < b keeps trial within WIDTH+1 bits
  assign trial = p[2*WIDTH-1:WIDTH-1] - {1'b0, b_r};
  assign ge = !trial[WIDTH];
  assign p_next = is_div ? {ge ? trial[WIDTH-1:0] : p[2*WIDTH-2:WIDTH-1], p[WIDTH-2:0], ge}
                         : {mac, p[WIDTH-1:1]};
`else
  assign is_div = 1'b0;
  assign p_next = {mac, p[WIDTH-1:1]};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      result <= '0;
      remainder <= '0;
      overflow <= 1'b0;
      error <= 1'b0;
      cnt <= '0;
      p <= '0;
      a_r <= '0;
`ifdef ARITH_ENGINE_DIV_EN
      b_r <= '0;
      is_div <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          overflow <= 1'b0;
          error <= 1'b0;
          remainder <= '0;
          a_r <= operand_a;
          cnt <= CW'(WIDTH);
`ifdef ARITH_ENGINE_DIV_EN
          b_r <= operand_b;
          is_div <= op[0];
`endif
          if (!op[1]) begin
            result <= sum[WIDTH-1:0];
            overflow <= sum[WIDTH];
            out_valid <= 1'b1;
            state <= DONE;
          end else if (!op[0]) begin
            p <= {{WIDTH{1'b0}}, operand_b};
            state <= CALC;
          end else begin
`ifdef ARITH_ENGINE_DIV_EN
            if (operand_b == '0) begin
              result <= '1;
              remainder <= operand_a;
              error <= 1'b1;
              out_valid <= 1'b1;
              state <= DONE;
            end else begin
              p <= {{WIDTH{1'b0}}, operand_a};
              state <= CALC;
            end
`else
            result <= '0;
            error <= 1'b1;
            out_valid <= 1'b1;
            state <= DONE;
`endif
          end
        end
        CALC: begin
          p <= p_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result <= p_next[WIDTH-1:0];
            remainder <= is_div ? p_next[2*WIDTH-1:WIDTH] : '0;
            overflow <= !is_div && |p_next[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
